// File: rtl/snake_move_control_if.sv
// Key/start/grow inputs and segment/status outputs of the snake movement controller.
// x[0]/y[0] is the head; x[15]/y[15] is the last possible tail segment.
interface snake_move_control_if;
    logic        Key_Up;
    logic        Key_Down;
    logic        Key_Left;
    logic        Key_Right;
    logic        Start_Sig;
    logic        Grow_Sig;
    logic [10:0] x [16];
    logic [10:0] y [16];
    logic [4:0]  Length;
    logic        Move_Tick;
    logic        Over_Sig;

    modport master (
        input  Key_Up, Key_Down, Key_Left, Key_Right, Start_Sig, Grow_Sig,
        output x, y, Length, Move_Tick, Over_Sig
    );

    modport slave (
        output Key_Up, Key_Down, Key_Left, Key_Right, Start_Sig, Grow_Sig,
        input  x, y, Length, Move_Tick, Over_Sig
    );
endinterface

// File: rtl/snake_move_control.sv
// Snake movement/game-state controller: move timing, steering, growth, collisions.
// Optional macro WRAP_EN: field edges wrap around instead of ending the game.
module snake_move_control #(
    parameter int unsigned MOVE_DIV = 2500000,
    parameter int unsigned STEP     = 6,
    parameter int unsigned X_MIN    = 20,
    parameter int unsigned X_MAX    = 284,
    parameter int unsigned Y_MIN    = 20,
    parameter int unsigned Y_MAX    = 284,
    parameter int unsigned PARK     = 1000
) (
    input logic                   CLK,
    input logic                   RST,
    snake_move_control_if.master  bus
);
    localparam int unsigned     CntW    = (MOVE_DIV > 2) ? $clog2(MOVE_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MOVE_DIV - 1);
    localparam logic [10:0]     Step    = 11'(STEP);
    localparam logic [10:0]     XMin    = 11'(X_MIN);
    localparam logic [10:0]     XMax    = 11'(X_MAX);
    localparam logic [10:0]     YMin    = 11'(Y_MIN);
    localparam logic [10:0]     YMax    = 11'(Y_MAX);
    localparam logic [10:0]     Park    = 11'(PARK);

    // Bit 1 selects the axis, bit 0 the sense, so opposites differ only in bit 0.
    localparam logic [1:0] DirRight = 2'b00;
    localparam logic [1:0] DirLeft  = 2'b01;
    localparam logic [1:0] DirUp    = 2'b10;
    localparam logic [1:0] DirDown  = 2'b11;

    typedef enum logic [1:0] {StIdle, StRun, StOver} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic [1:0]      dir_q, dir_pend_q;
    logic            grow_q;
    logic [4:0]      len_q;
    logic            tick_q, over_q;
    logic [10:0]     seg_x_q [16];
    logic [10:0]     seg_y_q [16];

    logic        load_init, move_eval, move_do, collide, wall, self_hit;
    logic        key_any, key_ok;
    logic [1:0]  key_dir, ref_dir;
    logic [10:0] raw_x, raw_y, head_x, head_y;
    logic [4:0]  new_len;

    // State register
    always_ff @(posedge CLK) begin
        if (RST) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus.Start_Sig) state_d = StRun;
            StRun:   if (move_eval && collide) state_d = StOver;
            StOver:  if (bus.Start_Sig) state_d = StRun;
            default: state_d = StIdle;
        endcase
    end

    // Control strobes decoded from the state
    always_comb begin
        load_init = 1'b0;
        move_eval = 1'b0;
        unique case (state_q)
            StIdle, StOver: load_init = bus.Start_Sig;
            StRun:          move_eval = (cnt_q == CntLast);
            default:        load_init = 1'b0;
        endcase
    end

    assign move_do = move_eval && !collide;
    assign new_len = (grow_q && (len_q != 5'd16)) ? len_q + 5'd1 : len_q;

    // Steering request: Up > Down > Left > Right; reversal of travel is refused.
    always_comb begin
        key_any = 1'b1;
        key_dir = DirRight;
        if (bus.Key_Up)         key_dir = DirUp;
        else if (bus.Key_Down)  key_dir = DirDown;
        else if (bus.Key_Left)  key_dir = DirLeft;
        else if (bus.Key_Right) key_dir = DirRight;
        else                    key_any = 1'b0;
        ref_dir = move_do ? dir_pend_q : dir_q;
        key_ok  = key_any && !((key_dir[1] == ref_dir[1]) && (key_dir[0] != ref_dir[0]));
    end

    always_comb begin
        raw_x = seg_x_q[0];
        raw_y = seg_y_q[0];
        unique case (dir_pend_q)
            DirRight: raw_x = seg_x_q[0] + Step;
            DirLeft:  raw_x = seg_x_q[0] - Step;
            DirUp:    raw_y = seg_y_q[0] - Step;
            default:  raw_y = seg_y_q[0] + Step;
        endcase
        head_x = raw_x;
        head_y = raw_y;
`ifdef WRAP_EN
        wall = 1'b0;
        if (raw_x < XMin)      head_x = XMax;
        else if (raw_x > XMax) head_x = XMin;
        if (raw_y < YMin)      head_y = YMax;
        else if (raw_y > YMax) head_y = YMin;
`else
        wall = (raw_x < XMin) || (raw_x > XMax) || (raw_y < YMin) || (raw_y > YMax);
`endif
    end

    // A pending growth keeps the tail in place, so it becomes an obstacle too.
    always_comb begin
        self_hit = 1'b0;
        for (int i = 1; i < 16; i++) begin
            if ((i + 2 <= int'(len_q)) || (grow_q && (i + 1 == int'(len_q)))) begin
                if ((seg_x_q[i] == head_x) && (seg_y_q[i] == head_y)) self_hit = 1'b1;
            end
        end
        collide = wall || self_hit;
    end

    always_ff @(posedge CLK) begin
        if (RST || load_init) begin
            cnt_q      <= '0;
            dir_q      <= DirRight;
            dir_pend_q <= DirRight;
            grow_q     <= 1'b0;
            len_q      <= 5'd3;
            tick_q     <= 1'b0;
            over_q     <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                seg_x_q[i] <= Park;
                seg_y_q[i] <= Park;
            end
            seg_x_q[0] <= 11'd80;
            seg_x_q[1] <= 11'd74;
            seg_x_q[2] <= 11'd68;
            seg_y_q[0] <= 11'd80;
            seg_y_q[1] <= 11'd80;
            seg_y_q[2] <= 11'd80;
        end else begin
            tick_q <= move_do;
            over_q <= (state_d == StOver);
            cnt_q  <= ((state_q == StRun) && !move_eval) ? cnt_q + CntW'(1) : '0;
            if (key_ok) dir_pend_q <= key_dir;
            if (move_do) begin
                dir_q  <= dir_pend_q;
                grow_q <= 1'b0;
                len_q  <= new_len;
                seg_x_q[0] <= head_x;
                seg_y_q[0] <= head_y;
                for (int i = 1; i < 16; i++) begin
                    seg_x_q[i] <= (i < int'(new_len)) ? seg_x_q[i-1] : Park;
                    seg_y_q[i] <= (i < int'(new_len)) ? seg_y_q[i-1] : Park;
                end
            end
            if ((state_q == StRun) && bus.Grow_Sig) grow_q <= 1'b1;
        end
    end

    assign bus.x         = seg_x_q;
    assign bus.y         = seg_y_q;
    assign bus.Length    = len_q;
    assign bus.Move_Tick = tick_q;
    assign bus.Over_Sig  = over_q;
endmodule

// File: tb/tb_snake_move_control.sv
// Self-checking bench for snake_move_control: move vectors, growth, collisions, reset.
module tb_snake_move_control;
    localparam int unsigned MoveDiv = 4;
    localparam logic [10:0] Park    = 11'd1000;

    typedef struct packed {
        logic [3:0]  keys;   // {up, down, left, right}
        logic        grow;
        logic        start;
        logic        tick;
        logic        over;
        logic [10:0] hx;
        logic [10:0] hy;
        logic [4:0]  len;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t sb [$];
    logic [21:0] hist [$];   // expected segment positions, head first
    vec_t g1 [18];
    vec_t g3 [5];

    snake_move_control_if bus ();

    snake_move_control #(.MOVE_DIV(MoveDiv)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] keys, input logic grow, input logic start,
                                input logic tick, input logic over, input int hx, input int hy,
                                input int len);
        vec_t v;
        v.keys = keys; v.grow = grow; v.start = start; v.tick = tick; v.over = over;
        v.hx = 11'(hx); v.hy = 11'(hy); v.len = 5'(len);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_body(input int len);
        for (int i = 0; i < 16; i++) begin
            logic [21:0] p;
            p = (i < len) ? hist[i] : {Park, Park};
            check($sformatf("x%0d", i), 32'(bus.x[i]), 32'(p[21:11]));
            check($sformatf("y%0d", i), 32'(bus.y[i]), 32'(p[10:0]));
        end
    endtask

    task automatic init_hist();
        hist = {};
        hist.push_back({11'd80, 11'd80});
        hist.push_back({11'd74, 11'd80});
        hist.push_back({11'd68, 11'd80});
    endtask

    task automatic clear_inputs();
        bus.Key_Up = 1'b0; bus.Key_Down = 1'b0; bus.Key_Left = 1'b0; bus.Key_Right = 1'b0;
        bus.Start_Sig = 1'b0; bus.Grow_Sig = 1'b0;
    endtask

    task automatic check_init(input string tag);
        init_hist();
        check({tag, "_len"}, 32'(bus.Length), 32'd3);
        check({tag, "_tick"}, 32'(bus.Move_Tick), 32'd0);
        check({tag, "_over"}, 32'(bus.Over_Sig), 32'd0);
        check_body(3);
    endtask

    // Drive one move interval; the result must appear exactly MoveDiv cycles later.
    task automatic apply_vec(input vec_t v);
        vec_t e;
        {bus.Key_Up, bus.Key_Down, bus.Key_Left, bus.Key_Right} = v.keys;
        bus.Grow_Sig  = v.grow;
        bus.Start_Sig = v.start;
        sb.push_back(v);
        for (int k = 1; k <= int'(MoveDiv); k++) begin
            @(negedge clk);
            if (k == 1) clear_inputs();
            if (k < int'(MoveDiv)) check("tick_early", 32'(bus.Move_Tick), 32'd0);
        end
        e = sb.pop_front();
        check("move_tick", 32'(bus.Move_Tick), 32'(e.tick));
        check("over_sig", 32'(bus.Over_Sig), 32'(e.over));
        check("length", 32'(bus.Length), 32'(e.len));
        if (e.tick) hist.push_front({e.hx, e.hy});
        check("head_x", 32'(bus.x[0]), 32'(e.hx));
        check("head_y", 32'(bus.y[0]), 32'(e.hy));
        check_body(int'(e.len));
    endtask

    task automatic do_start();
        bus.Start_Sig = 1'b1;
        @(negedge clk);
        bus.Start_Sig = 1'b0;
        check_init("start");
    endtask

    initial begin
        g1[0]  = mk(4'b0000, 0, 0, 1, 0, 86, 80, 3);
        g1[1]  = mk(4'b0010, 0, 0, 1, 0, 92, 80, 3);
        g1[2]  = mk(4'b1011, 0, 0, 1, 0, 92, 74, 3);
        g1[3]  = mk(4'b0000, 1, 0, 1, 0, 92, 68, 4);
        g1[4]  = mk(4'b0001, 1, 0, 1, 0, 98, 68, 5);
        for (int i = 5; i <= 15; i++) g1[i] = mk(4'b0000, 1, 0, 1, 0, 98 + 6 * (i - 4), 68, i + 1);
        g1[16] = mk(4'b0000, 1, 0, 1, 0, 170, 68, 16);
        g1[17] = mk(4'b0000, 0, 0, 1, 0, 176, 68, 16);

        g3[0] = mk(4'b0000, 1, 0, 1, 0, 86, 80, 4);
        g3[1] = mk(4'b0000, 1, 0, 1, 0, 92, 80, 5);
        g3[2] = mk(4'b1000, 0, 1, 1, 0, 92, 74, 5);
        g3[3] = mk(4'b0011, 0, 0, 1, 0, 86, 74, 5);
        g3[4] = mk(4'b0100, 0, 0, 0, 1, 86, 74, 5);

        clear_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_init("reset");
        rst = 1'b0;

        // IDLE: grow is ignored and nothing moves without a start.
        bus.Grow_Sig = 1'b1;
        @(negedge clk);
        bus.Grow_Sig = 1'b0;
        for (int k = 0; k < 3 * int'(MoveDiv); k++) begin
            @(negedge clk);
            check("idle_tick", 32'(bus.Move_Tick), 32'd0);
        end
        check_init("idle");

        do_start();
        foreach (g1[i]) apply_vec(g1[i]);

        // Reset mid-run with the tick counter at 2.
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_init("mid_rst");
        rst = 1'b0;
        for (int k = 0; k < 2 * int'(MoveDiv); k++) begin
            @(negedge clk);
            check("rst_idle_tick", 32'(bus.Move_Tick), 32'd0);
        end
        check("rst_idle_x0", 32'(bus.x[0]), 32'd80);

        do_start();
        foreach (g3[i]) apply_vec(g3[i]);
        for (int k = 0; k < int'(MoveDiv); k++) begin
            @(negedge clk);
            check("over_tick", 32'(bus.Move_Tick), 32'd0);
            check("over_hold", 32'(bus.Over_Sig), 32'd1);
        end
        check_body(5);

        do_start();
        for (int k = 1; k <= 34; k++) apply_vec(mk(4'b0000, 0, 0, 1, 0, 80 + 6 * k, 80, 3));
`ifdef WRAP_EN
        apply_vec(mk(4'b0000, 0, 0, 1, 0, 20, 80, 3));
`else
        apply_vec(mk(4'b0000, 0, 0, 0, 1, 284, 80, 3));
        do_start();
        apply_vec(mk(4'b0000, 0, 0, 1, 0, 86, 80, 3));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
